udma_cfg_apb_master: RTL
========================

Name: udma_cfg_apb_master

Overview:
- Initiator side of the uDMA peripheral configuration bus.
- Accepts APB3 transfers from the SoC interconnect and decodes the target peripheral from the upper address bits.
- Drives the cfg_data/cfg_addr/cfg_valid/cfg_rwn interface of up to N_PERIPH peripheral register interfaces (e.g. the Ethernet channel) and waits for cfg_ready.
- Returns read data or an error to APB; guarantees exactly one cfg_valid cycle per accepted beat, because peripheral reads have side effects (read-to-clear error registers).

Parameters:
- APB_AWIDTH, 12, APB address width.
- N_PERIPH, 4, number of attached peripheral cfg ports.
- PERIPH_IDX_W, 2, width of peripheral index field; must satisfy 2**PERIPH_IDX_W >= N_PERIPH.
- TIMEOUT, 255, cycles to wait for cfg_ready before the access errors; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- paddr_i  in  APB_AWIDTH  APB address
- pwdata_i  in  32  APB write data
- pwrite_i  in  1  1=write
- psel_i  in  1  APB select
- penable_i  in  1  APB enable
- prdata_o  out  32  APB read data
- pready_o  out  1  APB ready
- pslverr_o  out  1  APB error
- cfg_data_o  out  32  write data to peripherals (shared)
- cfg_addr_o  out  5  register word address (shared)
- cfg_rwn_o  out  1  1=read, 0=write (shared)
- cfg_valid_o  out  N_PERIPH  one-hot request per peripheral
- cfg_data_i  in  32*N_PERIPH  read data; slice k belongs to peripheral k
- cfg_ready_i  in  N_PERIPH  per-peripheral ready

Behaviour:
- Clock and reset: one clock, clk_i. Reset is rstn_i, asynchronous and active-low.
- Reset values: all outputs 0. FSM in IDLE, timeout counter 0.
- Address decode:
  - cfg_addr = paddr_i[6:2].
  - idx = paddr_i[7+PERIPH_IDX_W-1:7].
  - paddr_i[1:0] and bits above the idx field are ignored.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - On psel_i & ~penable_i (setup phase), latch addr, pwdata, pwrite and idx into registers.
  - If idx >= N_PERIPH, set err flag and go to RESP (no cfg_valid ever asserted).
  - Otherwise clear the counter and go to ISSUE.
- ISSUE:
  - cfg_valid_o[idx]=1; all other bits 0.
  - cfg_rwn_o = ~latched pwrite.
  - cfg_addr_o and cfg_data_o come from the latched values and are stable for the whole ISSUE state.
  - If cfg_ready_i[idx]=1 this cycle:
    - capture cfg_data_i[idx*32 +: 32] into the prdata register on reads, or 0 on writes;
    - err=0;
    - go to RESP.
  - Else, when TIMEOUT!=0 and counter==TIMEOUT-1: err=1, prdata=0, go to RESP.
  - Else counter++ (saturating).
- RESP:
  - pready_o=1 and pslverr_o=err for exactly one cycle; prdata_o is valid this cycle.
  - Go to IDLE; next cycle pready_o=0 and prdata_o is cleared to 0.
- cfg_valid_o is 0 in IDLE and RESP. The FSM never re-enters ISSUE for the same beat, so a peripheral sees exactly one valid-and-ready cycle per transfer.
- Latency, peripheral with cfg_ready tied 1:
  - setup at T0, ISSUE at T1, pready at T2;
  - 3-cycle APB transfer (one wait state).
  - Each peripheral stall cycle adds one cycle.
- pready_o is 0 outside RESP. APB master sequencing violations (penable without a prior setup phase) are ignored in IDLE.
- Back-to-back transfers: a new setup phase in the cycle after RESP is accepted normally. A setup phase arriving during RESP is not possible under APB.
- cfg_data_o and cfg_addr_o hold their last values in IDLE; only cfg_valid qualifies them.
- Reset mid-operation: cfg_valid_o and pready_o drop asynchronously; the in-flight beat is lost and no response is given.
- Simultaneous ready and timeout in the same cycle: ready wins, err=0.

Decomposition:
- Package udma_cfg_pkg holds:
  - FSM enum cfg_mst_state_e {IDLE, ISSUE, RESP};
  - constants CFG_ADDR_W=5 and CFG_DATA_W=32;
  - local parameter REG_IDX_LSB=2 and the periph field LSB=7.
- Single module; no sub-module needed. The one-hot valid decode and the data mux stay inline.

Test Plan:
- Write, ready tied 1: APB write 0x0000_0104 to paddr 0x0A8 (idx1, reg 0x0A)
  - -> cfg_valid_o=4'b0010 for exactly one cycle;
  - cfg_addr_o=5'h0A, cfg_rwn_o=0, cfg_data_o=0x0000_0104;
  - pready at T2, pslverr=0.
- Read, 3 ready stall cycles: peripheral 2 drives 0xDEAD_BEEF, APB read paddr 0x118
  - -> cfg_valid_o=4'b0100 held 4 cycles with stable addr 5'h06;
  - prdata=0xDEAD_BEEF, pready at T5.
- Timeout: TIMEOUT=8, ready never asserted
  - -> cfg_valid held 8 cycles, then pready=1, pslverr=1, prdata=0.
- Bad index: N_PERIPH=3, access idx 3 (paddr 0x180)
  - -> cfg_valid_o stays 0, pready at T1, pslverr=1.
- Reset during ISSUE: deassert rstn_i while cfg_valid_o=1
  - -> cfg_valid_o and pready_o go 0 immediately;
  - the next transfer after reset release completes normally.
- Back-to-back: read then write on consecutive APB transfers to peripheral 0
  - -> two separate single-cycle valid pulses;
  - read data is not corrupted by the write.

Source files
------------

// File: rtl/udma_cfg_pkg.sv
// Shared types and constants for the uDMA peripheral configuration bus master.
package udma_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } cfg_mst_state_e;

    localparam int CFG_ADDR_W     = 5;
    localparam int CFG_DATA_W     = 32;
    localparam int REG_IDX_LSB    = 2;
    localparam int PERIPH_IDX_LSB = 7;

endpackage

// File: rtl/udma_cfg_apb_master_if.sv
// APB3 bus bundle between the SoC interconnect (master) and the cfg master (slave).
interface udma_cfg_apb_master_if #(
    parameter int AWIDTH = 12
);
    logic [AWIDTH-1:0] paddr;
    logic [31:0]       pwdata;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/udma_cfg_apb_master.sv
// APB3 to uDMA cfg bridge: one cfg_valid beat per accepted APB transfer, with
// peripheral decode from the upper address bits and an optional ready timeout.
module udma_cfg_apb_master
    import udma_cfg_pkg::*;
#(
    parameter int APB_AWIDTH   = 12,
    parameter int N_PERIPH     = 4,
    parameter int PERIPH_IDX_W = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    udma_cfg_apb_master_if.slave      apb,
    output logic [CFG_DATA_W-1:0]     cfg_data_o,
    output logic [CFG_ADDR_W-1:0]     cfg_addr_o,
    output logic                      cfg_rwn_o,
    output logic [N_PERIPH-1:0]       cfg_valid_o,
    input  logic [32*N_PERIPH-1:0]    cfg_data_i,
    input  logic [N_PERIPH-1:0]       cfg_ready_i
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic               TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0]   TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    cfg_mst_state_e            state_q, state_d;
    logic [CFG_ADDR_W-1:0]     addr_q, addr_d;
    logic [CFG_DATA_W-1:0]     data_q, data_d;
    logic                      rwn_q, rwn_d;
    logic [PERIPH_IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [N_PERIPH-1:0]       valid_q, valid_d;
    logic                      pready_q, pready_d;
    logic                      pslverr_q, pslverr_d;
    logic [CFG_DATA_W-1:0]     prdata_q, prdata_d;

    logic                      setup_s;
    logic [PERIPH_IDX_W-1:0]   idx_s;
    logic                      idx_ok_s;
    logic [N_PERIPH-1:0]       onehot_s;
    logic                      sel_ready_s;
    logic [CFG_DATA_W-1:0]     sel_data_s;
    logic                      timeout_hit_s;
    logic                      unused_s;

    assign setup_s       = apb.psel & ~apb.penable;
    assign idx_s         = apb.paddr[PERIPH_IDX_LSB +: PERIPH_IDX_W];
    assign idx_ok_s      = ({1'b0, idx_s} < (PERIPH_IDX_W + 1)'(N_PERIPH));
    assign timeout_hit_s = TO_EN && (cnt_q == TO_LAST);
    assign unused_s      = ^apb.paddr;

    // Peripheral decode: one-hot request for the incoming index, ready/data mux for the latched one.
    always_comb begin
        onehot_s    = '0;
        sel_ready_s = 1'b0;
        sel_data_s  = '0;
        for (int k = 0; k < N_PERIPH; k++) begin
            if (idx_s == PERIPH_IDX_W'(k)) begin
                onehot_s[k] = 1'b1;
            end else begin
                onehot_s[k] = 1'b0;
            end
            if (idx_q == PERIPH_IDX_W'(k)) begin
                sel_ready_s = cfg_ready_i[k];
                sel_data_s  = cfg_data_i[k*32 +: 32];
            end else begin
                sel_ready_s = sel_ready_s;
                sel_data_s  = sel_data_s;
            end
        end
    end

    // Next-state and registered-output logic; response outputs are one-cycle pulses by default.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rwn_d     = rwn_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        valid_d   = '0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        case (state_q)
            IDLE: begin
                if (setup_s) begin
                    addr_d = apb.paddr[REG_IDX_LSB +: CFG_ADDR_W];
                    data_d = apb.pwdata;
                    rwn_d  = ~apb.pwrite;
                    idx_d  = idx_s;
                    if (idx_ok_s) begin
                        cnt_d   = '0;
                        valid_d = onehot_s;
                        state_d = ISSUE;
                    end else begin
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        state_d   = RESP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                // Ready is checked before the timeout so a late ready still completes cleanly.
                if (sel_ready_s) begin
                    prdata_d = rwn_q ? sel_data_s : 32'h0000_0000;
                    pready_d = 1'b1;
                    state_d  = RESP;
                end else if (timeout_hit_s) begin
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    valid_d = valid_q;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            rwn_q     <= 1'b0;
            idx_q     <= '0;
            cnt_q     <= '0;
            valid_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rwn_q     <= rwn_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    assign cfg_data_o  = data_q;
    assign cfg_addr_o  = addr_q;
    assign cfg_rwn_o   = rwn_q;
    assign cfg_valid_o = valid_q;
    assign apb.prdata  = prdata_q;
    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;

endmodule
